// File: rtl/step_stats_pkg.sv
// Shared definitions for the step statistics stage: FSM encoding and default thresholds.
package step_stats_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPend   = 2'd1,
    StActive = 2'd2
  } hi_state_e;

  localparam int unsigned DefStepMax       = 9999;
  localparam int unsigned DefStepsPerHalfMi = 1024;
  localparam int unsigned DefRateThr       = 32;
  localparam int unsigned DefWinSecs       = 9;
  localparam int unsigned DefHiThr         = 64;
  localparam int unsigned DefHiMinRun      = 60;

endpackage

// File: rtl/step_stats_edge_rise.sv
// Single-register rising-edge detector; the delay register is never cleared except by reset.
module edge_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // One-cycle delayed copy of the input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/step_stats.sv
// Step statistics: total steps, distance, per-second rate, window count and high-activity time.
module step_stats
  import step_stats_pkg::*;
#(
  parameter int unsigned STEP_MAX         = DefStepMax,
  parameter int unsigned STEPS_PER_HALFMI = DefStepsPerHalfMi,
  parameter int unsigned RATE_THR         = DefRateThr,
  parameter int unsigned WIN_SECS         = DefWinSecs,
  parameter int unsigned HI_THR           = DefHiThr,
  parameter int unsigned HI_MIN_RUN       = DefHiMinRun
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        pulse,
  input  logic        clk_1hz,
  output logic [13:0] step_count,
  output logic        sat,
  output logic [3:0]  dist_half,
  output logic [7:0]  rate,
  output logic [3:0]  win_over,
  output logic [15:0] hi_secs
);

  localparam logic [13:0] StepMaxW  = 14'(STEP_MAX);
  localparam logic [9:0]  SubWrap   = 10'(STEPS_PER_HALFMI - 1);
  localparam logic [7:0]  RateThrW  = 8'(RATE_THR);
  localparam logic [3:0]  WinSecsW  = 4'(WIN_SECS);
  localparam logic [7:0]  HiThrW    = 8'(HI_THR);
  localparam logic [6:0]  HiMinRunW = 7'(HI_MIN_RUN);

  logic step, tick;

  edge_rise u_pulse_edge (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (pulse),
    .rise_o (step)
  );

  edge_rise u_hz_edge (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (clk_1hz),
    .rise_o (tick)
  );

  logic [13:0] step_count_q, step_count_d;
  logic        sat_q, sat_d;
  logic [9:0]  sub_cnt_q, sub_cnt_d;
  logic [3:0]  dist_q, dist_d;
  logic [7:0]  sec_cnt_q, sec_cnt_d;
  logic [7:0]  rate_q, rate_d;
  logic [3:0]  sec_idx_q, sec_idx_d;
  logic [3:0]  win_q, win_d;
  logic [15:0] hi_q, hi_d;
  logic [6:0]  run_q, run_d;
  hi_state_e   state_q, state_d;

  logic [8:0]  rate_sum;
  logic [7:0]  new_rate;
  logic        rate_hi;
  logic [6:0]  run_inc;
  logic [16:0] hi_add_run, hi_add_one;

  // Next-state for all statistics; clear overrides any coincident step or tick.
  always_comb begin
    step_count_d = step_count_q;
    sub_cnt_d    = sub_cnt_q;
    dist_d       = dist_q;
    sec_cnt_d    = sec_cnt_q;
    rate_d       = rate_q;
    sec_idx_d    = sec_idx_q;
    win_d        = win_q;
    hi_d         = hi_q;
    run_d        = run_q;
    state_d      = state_q;

    // A step landing on the tick belongs to the closing second as well as the new one.
    rate_sum   = {1'b0, sec_cnt_q} + {8'd0, step};
    new_rate   = rate_sum[8] ? 8'hff : rate_sum[7:0];
    rate_hi    = (new_rate >= HiThrW);
    run_inc    = run_q + 7'd1;
    hi_add_run = {1'b0, hi_q} + {10'd0, HiMinRunW};
    hi_add_one = {1'b0, hi_q} + 17'd1;

    if (clear) begin
      step_count_d = '0;
      sub_cnt_d    = '0;
      dist_d       = '0;
      sec_cnt_d    = '0;
      rate_d       = '0;
      sec_idx_d    = '0;
      win_d        = '0;
      hi_d         = '0;
      run_d        = '0;
      state_d      = StIdle;
    end else begin
      if (step && (step_count_q != StepMaxW)) begin
        step_count_d = step_count_q + 14'd1;
        if (sub_cnt_q == SubWrap) begin
          sub_cnt_d = '0;
          dist_d    = dist_q + 4'd1;
        end else begin
          sub_cnt_d = sub_cnt_q + 10'd1;
        end
      end

      if (tick) begin
        rate_d    = new_rate;
        sec_cnt_d = {7'd0, step};
        if (sec_idx_q != 4'hf) sec_idx_d = sec_idx_q + 4'd1;
        if ((sec_idx_q < WinSecsW) && (new_rate > RateThrW)) win_d = win_q + 4'd1;

        unique case (state_q)
          StIdle: begin
            if (rate_hi) begin
              run_d   = 7'd1;
              state_d = StPend;
            end
          end
          StPend: begin
            if (rate_hi) begin
              run_d = run_inc;
              if (run_inc == HiMinRunW) begin
                hi_d    = hi_add_run[16] ? 16'hffff : hi_add_run[15:0];
                state_d = StActive;
              end
            end else begin
              run_d   = '0;
              state_d = StIdle;
            end
          end
          StActive: begin
            if (rate_hi) begin
              hi_d = hi_add_one[16] ? 16'hffff : hi_add_one[15:0];
            end else begin
              run_d   = '0;
              state_d = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end else if (step && (sec_cnt_q != 8'hff)) begin
        sec_cnt_d = sec_cnt_q + 8'd1;
      end
    end

    sat_d = (step_count_d == StepMaxW);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count_q <= '0;
      sat_q        <= 1'b0;
      sub_cnt_q    <= '0;
      dist_q       <= '0;
      sec_cnt_q    <= '0;
      rate_q       <= '0;
      sec_idx_q    <= '0;
      win_q        <= '0;
      hi_q         <= '0;
      run_q        <= '0;
      state_q      <= StIdle;
    end else begin
      step_count_q <= step_count_d;
      sat_q        <= sat_d;
      sub_cnt_q    <= sub_cnt_d;
      dist_q       <= dist_d;
      sec_cnt_q    <= sec_cnt_d;
      rate_q       <= rate_d;
      sec_idx_q    <= sec_idx_d;
      win_q        <= win_d;
      hi_q         <= hi_d;
      run_q        <= run_d;
      state_q      <= state_d;
    end
  end

  assign step_count = step_count_q;
  assign sat        = sat_q;
  assign dist_half  = dist_q;
  assign rate       = rate_q;
  assign win_over   = win_q;
  assign hi_secs    = hi_q;

endmodule

// File: tb/tb_step_stats.sv
// Directed bench for step_stats: vector table plus hand-written multi-cycle sequences.
module tb_step_stats;
  import step_stats_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        pulse = 1'b0;
  logic        clk_1hz = 1'b0;
  logic [13:0] step_count;
  logic        sat;
  logic [3:0]  dist_half;
  logic [7:0]  rate;
  logic [3:0]  win_over;
  logic [15:0] hi_secs;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit clr;
    int steps;
    bit tick;
    int exp_cnt;
    int exp_dist;
    int exp_rate;
    int exp_win;
    int exp_hi;
    int exp_sat;
  } vec_t;

  vec_t vecs[$];

  step_stats dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .pulse      (pulse),
    .clk_1hz    (clk_1hz),
    .step_count (step_count),
    .sat        (sat),
    .dist_half  (dist_half),
    .rate       (rate),
    .win_over   (win_over),
    .hi_secs    (hi_secs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " step_count"}, int'(step_count), 0);
    chk({tag, " sat"}, int'(sat), 0);
    chk({tag, " dist_half"}, int'(dist_half), 0);
    chk({tag, " rate"}, int'(rate), 0);
    chk({tag, " win_over"}, int'(win_over), 0);
    chk({tag, " hi_secs"}, int'(hi_secs), 0);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) pulse = 1'b1;
      @(negedge clk) pulse = 1'b0;
    end
  endtask

  task automatic tick1();
    @(negedge clk) clk_1hz = 1'b1;
    @(negedge clk) clk_1hz = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    #12;
    chk_all_zero("reset");
    chk("reset state", int'(dut.state_q), int'(StIdle));
    @(negedge clk) rst_n = 1'b1;

    // Step count / distance rows, then rate/window rows at 40 and 32 steps per second.
    vecs.push_back('{1'b1, 0,    1'b0, 0,    0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1023, 1'b0, 1023, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1,    1'b0, 1024, 1, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1024, 1'b0, 2048, 2, 0, 0, 0, 0});
    for (int i = 1; i <= 12; i++)
      vecs.push_back('{(i == 1), 40, 1'b1, 40 * i, 0, 40, (i < 9) ? i : 9, 0, 0});
    for (int i = 1; i <= 12; i++)
      vecs.push_back('{(i == 1), 32, 1'b1, 32 * i, 0, 32, 0, 0, 0});

    foreach (vecs[v]) begin
      if (vecs[v].clr) do_clear();
      step_n(vecs[v].steps);
      if (vecs[v].tick) tick1();
      settle();
      chk($sformatf("vec%0d step_count", v), int'(step_count), vecs[v].exp_cnt);
      chk($sformatf("vec%0d dist_half", v), int'(dist_half), vecs[v].exp_dist);
      chk($sformatf("vec%0d rate", v), int'(rate), vecs[v].exp_rate);
      chk($sformatf("vec%0d win_over", v), int'(win_over), vecs[v].exp_win);
      chk($sformatf("vec%0d hi_secs", v), int'(hi_secs), vecs[v].exp_hi);
      chk($sformatf("vec%0d sat", v), int'(sat), vecs[v].exp_sat);
    end

    // High-activity run: 59 s at 64, a low second, then 61 s at 70.
    do_clear();
    for (int s = 0; s < 59; s++) begin
      step_n(64);
      tick1();
    end
    settle();
    chk("hi after 59 high", int'(hi_secs), 0);
    chk("state pend", int'(dut.state_q), int'(StPend));
    step_n(10);
    tick1();
    settle();
    chk("hi after low sec", int'(hi_secs), 0);
    chk("state idle after low", int'(dut.state_q), int'(StIdle));
    for (int s = 1; s <= 61; s++) begin
      step_n(70);
      tick1();
      settle();
      if (s == 59) chk("hi tick59", int'(hi_secs), 0);
      if (s == 60) begin
        chk("hi tick60", int'(hi_secs), 60);
        chk("state active", int'(dut.state_q), int'(StActive));
      end
      if (s == 61) begin
        chk("hi tick61", int'(hi_secs), 61);
        chk("rate 70", int'(rate), 70);
      end
    end

    // Clear in ACTIVE with a coincident step.
    @(negedge clk) begin
      pulse = 1'b1;
      clear = 1'b1;
    end
    @(negedge clk) begin
      pulse = 1'b0;
      clear = 1'b0;
    end
    chk_all_zero("clear");
    chk("clear state", int'(dut.state_q), int'(StIdle));
    step_n(1);
    settle();
    chk("count after clear", int'(step_count), 1);

    // Step coinciding with tick while sec_cnt is 5.
    do_clear();
    step_n(5);
    @(negedge clk) begin
      pulse = 1'b1;
      clk_1hz = 1'b1;
    end
    @(negedge clk) begin
      pulse = 1'b0;
      clk_1hz = 1'b0;
    end
    settle();
    chk("coincident rate", int'(rate), 6);
    chk("coincident sec_cnt", int'(dut.sec_cnt_q), 1);
    tick1();
    settle();
    chk("next second rate", int'(rate), 1);
    chk("coincident count", int'(step_count), 6);

    // Saturation.
    do_clear();
    step_n(9998);
    settle();
    chk("pre-sat count", int'(step_count), 9998);
    chk("pre-sat sat", int'(sat), 0);
    step_n(1);
    settle();
    chk("sat count", int'(step_count), 9999);
    chk("sat flag", int'(sat), 1);
    chk("sat dist", int'(dist_half), 9);
    step_n(51);
    settle();
    chk("post-sat count", int'(step_count), 9999);
    chk("post-sat flag", int'(sat), 1);
    chk("post-sat dist", int'(dist_half), 9);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(negedge clk) rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
